bcd_stopwatch_core: RTL and testbench
=====================================

Name: bcd_stopwatch_core

Overview:
- Four-digit BCD stopwatch/countdown engine that produces the val3..val0 nibbles consumed by quad_seven_seg.
- Takes raw push-button inputs, synchronizes them and edge-detects them, then counts hundredths of seconds at a prescaled rate.
- Display format is val3 val2 . val1 val0 = tens-sec, unit-sec, tenths, hundredths. Range 00.00 to 99.99.

Parameters:
- TICK_DIV, 1000000: clk cycles per count tick (100 MHz -> 10 ms); legal range 2 and up.
- PRESET, 16'h3000: BCD value loaded by clear in down mode ({val3,val2,val1,val0}); must be valid BCD.
- DEBOUNCE_CYC, 500000: stable-cycle count for button acceptance; used only when DEBOUNCE_EN is defined.

Ports:
- clk  in  1  system clock, 100 MHz, rising edge
- rst  in  1  synchronous, active-high reset
- btn_start  in  1  raw async button; rising edge toggles run/pause
- btn_clear  in  1  raw async button; rising edge clears/loads
- mode  in  1  0 = count up, 1 = count down; sampled on clear and on start
- val3  out  4  tens of seconds, BCD
- val2  out  4  units of seconds, BCD
- val1  out  4  tenths, BCD
- val0  out  4  hundredths, BCD
- running  out  1  high while in RUN
- done  out  1  high while in DONE (countdown expired)
- ovf  out  1  sticky; set when the up-count wraps 99.99 -> 00.00

Behaviour:
- Reset: all outputs are synchronous with clk; on rst all val = 4'h0, running = 0, done = 0, ovf = 0, state = IDLE, prescaler = 0, synchronizer and edge flops = 0. rst overrides every other input.
- Button path: 2-flop synchronizer, then a rising-edge detector that emits a 1-cycle pulse.
  - btn high, meeting setup before edge k, gives a pulse during cycle k+2; its action is visible on outputs after edge k+3.
  - A held button produces exactly one pulse.
- Latched direction: dir_q register, loaded from mode on every clear pulse and on every IDLE->RUN transition. Changes to mode are ignored during RUN.
- States: IDLE, RUN, DONE.
  - IDLE + start pulse -> RUN. Exception: if dir_q = down and value = 0000, stay in IDLE.
  - RUN + start pulse -> IDLE (pause). Value and prescaler are held.
  - RUN + down-count tick that produces 0000 -> DONE. done rises on the same edge the value becomes 0000.
  - DONE + start pulse -> ignored. DONE + clear pulse -> IDLE.
- Clear pulse, any state:
  - value = 0000 if mode = 0, PRESET if mode = 1;
  - prescaler = 0, ovf = 0, done = 0, state = IDLE.
- Simultaneous clear and start pulses: clear wins and start is dropped.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN, with tick asserted at TICK_DIV-1, then wraps to 0.
  - Held while in IDLE or DONE, and reset to 0 only by clear or rst.
  - The first tick after a fresh start occurs TICK_DIV cycles after entering RUN. The value updates on that tick edge.
- Up count:
  - BCD increment with ripple carry: a digit at 9 becomes 0 and carries.
  - 99.99 + 1 -> 00.00, ovf set to 1 on the same edge; counting continues.
- Down count:
  - BCD decrement with ripple borrow: a digit at 0 becomes 9 and borrows.
  - Never decrements below 0000, because DONE is entered first.
- Outputs are registered, with no combinational path from inputs to val*, running, done or ovf.
- Digits are always valid BCD (0..9).

Optional Feature:
- Macro: BCD_STOPWATCH_DEBOUNCE_EN.
- Defined: each synchronized button feeds a debouncer.
  - Accepted level changes only after the input is stable for DEBOUNCE_CYC consecutive cycles; any change restarts the count.
  - Edge detect operates on the accepted level, so action latency is DEBOUNCE_CYC+3 cycles.
  - Glitches shorter than DEBOUNCE_CYC produce no pulse.
- Undefined: no debouncer; latency 3 cycles as above. DEBOUNCE_CYC is unused.

Test Plan:
Run with TICK_DIV=4, PRESET=16'h0003, 10 ns clk.
1. Reset: rst held high for 3 cycles with buttons toggling -> val=0000, running=0, done=0, ovf=0 throughout. After release, outputs are unchanged.
2. Up count and pause:
   - mode=0, clear, then start -> running=1; val0 reaches 1 at 4 cycles after RUN entry and 2 after 8.
   - A start pulse after 3 ticks -> running=0, value holds 0003 for 100 cycles.
   - Restart -> 0004 exactly 4 cycles later, since the prescaler resumed.
3. Carry and wrap:
   - Run from clear through 0009->0010, 0099->0100 and 0999->1000.
   - At 9999 plus a tick -> 0000 with ovf=1, running stays 1.
   - Clear -> ovf=0.
4. Countdown:
   - mode=1, clear -> val=0003. Start -> 0002, 0001, 0000 at 4-cycle spacing.
   - done=1 and running=0 on the 0000 edge.
   - Further start pulses leave done=1. Clear -> 0003, done=0.
   - Start with value 0000 in mode 1 stays in IDLE.
5. Simultaneous events and edge detection:
   - Clear and start rising on the same cycle in RUN -> value reset, state IDLE, running=0.
   - Mode toggled during RUN -> direction unchanged.
   - btn_start held for 50 cycles -> exactly one toggle.
6. Debounce, with macro defined and DEBOUNCE_CYC=8:
   - 5-cycle pulse on btn_start -> no effect.
   - 12-cycle pulse -> running=1 exactly 11 cycles after the rising input.

Source files
------------

// File: rtl/bcd_stopwatch_core.sv
// rtl/bcd_stopwatch_core.sv - four-digit BCD stopwatch / countdown engine
// Optional feature macro: BCD_STOPWATCH_DEBOUNCE_EN (per-button debouncer).
// Ports: clk, rst (synchronous, active-high)
//        btn_start, btn_clear : raw asynchronous push buttons
//        mode                 : 0 = count up, 1 = count down
//        val3..val0           : BCD digits, tens-sec units-sec . tenths hundredths
//        running, done, ovf   : RUN state, DONE state, sticky up-count wrap flag
module bcd_stopwatch_core #(
    parameter int          TICK_DIV     = 1000000,
    parameter logic [15:0] PRESET       = 16'h3000,
    parameter int          DEBOUNCE_CYC = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       mode,
    output logic [3:0] val3,
    output logic [3:0] val2,
    output logic [3:0] val1,
    output logic [3:0] val0,
    output logic       running,
    output logic       done,
    output logic       ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    // A hierarchy containing this scope means TICK_DIV or DEBOUNCE_CYC is out of range.
    if (TICK_DIV < 2 || DEBOUNCE_CYC < 1) begin : g_illegal_params
    end

    state_t        state, state_n;
    logic [15:0]   value, value_n;
    logic [PW-1:0] presc, presc_n;
    logic          ovf_q, ovf_n;
    logic          dir_q, dir_n;

    // Button vectors: bit 0 = start, bit 1 = clear.
    logic [1:0] sync1, sync2, level, level_q, pulse;
    logic       start_p, clear_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {btn_clear, btn_start};
            sync2 <= sync1;
        end
    end

`ifdef BCD_STOPWATCH_DEBOUNCE_EN
    localparam int            DW      = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

    logic [DW-1:0] db_cnt [2];

    // The accepted level follows the synchronized input only after it has
    // differed from it for DEBOUNCE_CYC consecutive cycles.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                db_cnt[i] <= '0;
                level[i]  <= 1'b0;
            end else if (sync2[i] == level[i]) begin
                db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
                db_cnt[i] <= '0;
                level[i]  <= sync2[i];
            end else begin
                db_cnt[i] <= db_cnt[i] + 1'b1;
            end
        end
    end
`else
    assign level = sync2;
`endif

    // Registered rising-edge pulse: keeps inputs off any combinational path.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 2'b00;
            pulse   <= 2'b00;
        end else begin
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end

    assign start_p = pulse[0];
    assign clear_p = pulse[1];

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (c) begin
                if (v[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (b) begin
                if (v[4*d +: 4] == 4'd0) begin
                    r[4*d +: 4] = 4'd9;
                end else begin
                    r[4*d +: 4] = v[4*d +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            value <= 16'h0000;
            presc <= '0;
            ovf_q <= 1'b0;
            dir_q <= 1'b0;
        end else begin
            state <= state_n;
            value <= value_n;
            presc <= presc_n;
            ovf_q <= ovf_n;
            dir_q <= dir_n;
        end
    end

    always_comb begin
        state_n = state;
        value_n = value;
        presc_n = presc;
        ovf_n   = ovf_q;
        dir_n   = dir_q;
        if (clear_p) begin
            // Clear wins over a coincident start pulse.
            value_n = mode ? PRESET : 16'h0000;
            presc_n = '0;
            ovf_n   = 1'b0;
            dir_n   = mode;
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // Check against the direction about to be latched, so a
                    // down count can never start from 00.00.
                    if (start_p && !(mode && value == 16'h0000)) begin
                        state_n = RUN;
                        dir_n   = mode;
                    end
                end
                RUN: begin
                    if (start_p) begin
                        state_n = IDLE;
                    end else if (presc == TICK_LAST) begin
                        presc_n = '0;
                        if (dir_q) begin
                            value_n = bcd_dec(value);
                            if (value_n == 16'h0000) begin
                                state_n = DONE;
                            end
                        end else begin
                            value_n = bcd_inc(value);
                            if (value == 16'h9999) begin
                                ovf_n = 1'b1;
                            end
                        end
                    end else begin
                        presc_n = presc + 1'b1;
                    end
                end
                default: begin
                    // DONE waits for a clear pulse.
                end
            endcase
        end
    end

    assign {val3, val2, val1, val0} = value;
    assign running = (state == RUN);
    assign done    = (state == DONE);
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_stopwatch_core.sv
// tb/tb_bcd_stopwatch_core.sv - randomized self-checking bench for bcd_stopwatch_core
module tb_bcd_stopwatch_core;

    localparam int          TICK_DIV     = 4;
    localparam logic [15:0] PRESET       = 16'h0003;
    localparam int          DEBOUNCE_CYC = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start;
    logic       btn_clear;
    logic       mode;
    logic [3:0] val3, val2, val1, val0;
    logic       running, done, ovf;

    int checks = 0;
    int errors = 0;

    bcd_stopwatch_core #(
        .TICK_DIV     (TICK_DIV),
        .PRESET       (PRESET),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .mode      (mode),
        .val3      (val3),
        .val2      (val2),
        .val1      (val1),
        .val0      (val0),
        .running   (running),
        .done      (done),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

`ifndef BCD_STOPWATCH_DEBOUNCE_EN
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    // Reference model: value kept as an integer count of hundredths.
    int m_cnt, m_presc, m_state;
    bit m_ovf, m_dir;
    bit hs [4];
    bit hc [4];
    int preset_int;
    int cov_wrap = 0, cov_done = 0, cov_block = 0, cov_pause = 0;

    function automatic int from_bcd(input logic [15:0] b);
        return 1000 * int'(b[15:12]) + 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // Applies the rules at one rising edge. A button level sampled at edge k
    // acts at edge k+3 when the level one edge earlier was low.
    task automatic model_edge();
        bit st, cl;
        if (rst) begin
            m_cnt = 0; m_presc = 0; m_ovf = 0; m_dir = 0; m_state = S_IDLE;
            for (int i = 0; i < 4; i++) begin
                hs[i] = 0;
                hc[i] = 0;
            end
            return;
        end
        st = hs[1] && !hs[0];
        cl = hc[1] && !hc[0];
        for (int i = 0; i < 3; i++) begin
            hs[i] = hs[i+1];
            hc[i] = hc[i+1];
        end
        hs[3] = btn_start;
        hc[3] = btn_clear;
        if (cl) begin
            m_cnt = mode ? preset_int : 0;
            m_presc = 0; m_ovf = 0; m_dir = mode; m_state = S_IDLE;
        end else if (m_state == S_IDLE) begin
            if (st) begin
                if (mode && m_cnt == 0) cov_block++;
                else begin
                    m_state = S_RUN;
                    m_dir = mode;
                end
            end
        end else if (m_state == S_RUN) begin
            if (st) begin
                m_state = S_IDLE;
                cov_pause++;
            end else if (m_presc == TICK_DIV - 1) begin
                m_presc = 0;
                if (m_dir) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_state = S_DONE;
                        cov_done++;
                    end
                end else if (m_cnt == 9999) begin
                    m_cnt = 0;
                    m_ovf = 1;
                    cov_wrap++;
                end else begin
                    m_cnt++;
                end
            end else begin
                m_presc++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("val", {val3, val2, val1, val0}, to_bcd(m_cnt));
        check("running", running, m_state == S_RUN);
        check("done", done, m_state == S_DONE);
        check("ovf", ovf, m_ovf);
        @(negedge clk);
    endtask

    task automatic press(input bit s, input bit c, input int len, input int gap);
        btn_start = s;
        btn_clear = c;
        repeat (len) step();
        btn_start = 1'b0;
        btn_clear = 1'b0;
        repeat (gap) step();
    endtask

    initial begin
        preset_int = from_bcd(PRESET);
        rst = 1'b1; btn_start = 1'b0; btn_clear = 1'b0; mode = 1'b0;
        @(negedge clk);
        repeat (3) begin
            btn_start = 1'($urandom);
            btn_clear = 1'($urandom);
            mode      = 1'($urandom);
            step();
        end
        rst = 1'b0; btn_start = 1'b0; btn_clear = 1'b0; mode = 1'b0;
        repeat (10) step();

        // Directed countdown, including start blocked at 00.00 in down mode.
        mode = 1'b1;
        press(1, 0, 1, 2);
        press(0, 1, 3, 4);
        press(1, 0, 2, 20);
        press(1, 0, 2, 6);
        press(0, 1, 2, 6);
        mode = 1'b0;
        press(0, 1, 2, 6);
        mode = 1'b1;
        press(1, 0, 50, 10);

        repeat (160) begin
            case ($urandom_range(0, 5))
                0, 1: press(1, 0, $urandom_range(1, 50), $urandom_range(1, 20));
                2:    press(0, 1, $urandom_range(1, 10), $urandom_range(1, 20));
                3:    press(1, 1, $urandom_range(1, 10), $urandom_range(1, 20));
                4: begin
                    mode = 1'($urandom);
                    repeat ($urandom_range(1, 20)) step();
                end
                default: repeat ($urandom_range(1, 60)) step();
            endcase
        end

        // Full up-count sweep through every carry and the 99.99 wrap.
        mode = 1'b0;
        press(0, 1, 2, 4);
        press(1, 0, 3, 0);
        repeat (10000 * TICK_DIV + 20) step();
        press(0, 1, 2, 6);

        check("cov_wrap_seen", cov_wrap > 0, 1);
        check("cov_done_seen", cov_done > 0, 1);
        check("cov_block_seen", cov_block > 0, 1);
        check("cov_pause_seen", cov_pause > 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
`else
    task automatic step_raw();
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; btn_start = 1'b0; btn_clear = 1'b0; mode = 1'b0;
        @(negedge clk);
        repeat (3) begin
            btn_start = 1'($urandom);
            btn_clear = 1'($urandom);
            step_raw();
            check("rst_val", {val3, val2, val1, val0}, 16'h0000);
            check("rst_running", running, 0);
            check("rst_done", done, 0);
            check("rst_ovf", ovf, 0);
        end
        rst = 1'b0; btn_start = 1'b0; btn_clear = 1'b0;
        repeat (10) step_raw();

        btn_start = 1'b1;
        repeat (5) step_raw();
        btn_start = 1'b0;
        repeat (30) step_raw();
        check("glitch_running", running, 0);
        check("glitch_val", {val3, val2, val1, val0}, 16'h0000);

        btn_start = 1'b1;
        repeat (11) step_raw();
        check("db_before", running, 0);
        step_raw();
        check("db_at_latency", running, 1);
        btn_start = 1'b0;
        repeat (30) step_raw();
        check("db_release_no_toggle", running, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
`endif

endmodule
